// File: rtl/mvm_pkg.sv
// Shared widths, flit record and packer state for the mvm AXI-stream word packer.
package mvm_pkg;
  localparam int unsigned AXIS_DATA_W    = 512;
  localparam int unsigned AXIS_KEEP_W    = 64;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_FLIT = 16;
  localparam int unsigned ID_W           = 8;
  localparam int unsigned DEST_W         = 8;
  localparam int unsigned USER_W         = 32;
  localparam int unsigned COUNT_W        = $clog2(WORDS_PER_FLIT);
  localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic [ID_W-1:0]        id;
    logic [DEST_W-1:0]      dest;
    logic [USER_W-1:0]      user;
    logic                   last;
  } flit_t;
endpackage

// File: rtl/mvm_axis_out_reg.sv
// AXI-stream output register: holds one flit stable until the downstream
// handshake, and accepts a new flit in the same cycle the old one drains.
module mvm_axis_out_reg
  import mvm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  flit_t                  flit,
  input  logic                   tx_tready,
  output logic                   slot_free,
  output logic                   tx_tvalid,
  output logic [AXIS_DATA_W-1:0] tx_tdata,
  output logic [AXIS_KEEP_W-1:0] tx_tstrb,
  output logic [AXIS_KEEP_W-1:0] tx_tkeep,
  output logic [ID_W-1:0]        tx_tid,
  output logic [DEST_W-1:0]      tx_tdest,
  output logic [USER_W-1:0]      tx_tuser,
  output logic                   tx_tlast
);

  flit_t held;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_tvalid <= 1'b0;
      held      <= '0;
    end else if (load) begin
      tx_tvalid <= 1'b1;
      held      <= flit;
    end else if (tx_tready) begin
      tx_tvalid <= 1'b0;
    end
  end

  assign slot_free = !tx_tvalid || tx_tready;

  assign tx_tdata = held.data;
  assign tx_tkeep = held.keep;
  assign tx_tstrb = held.keep;
  assign tx_tid   = held.id;
  assign tx_tdest = held.dest;
  assign tx_tuser = held.user;
  assign tx_tlast = held.last;

endmodule

// File: rtl/mvm_word_packer.sv
// Packs 32-bit words into 512-bit AXI-stream flits (16 words or in_last).
// Optional idle flush of partial flits: define MVM_PACKER_FLUSH_TIMEOUT_EN.
module mvm_word_packer
  import mvm_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic [ID_W-1:0]        cfg_tid,
  input  logic [DEST_W-1:0]      cfg_tdest,
  input  logic [USER_W-1:0]      cfg_tuser,
  output logic                   tx_tvalid,
  output logic [AXIS_DATA_W-1:0] tx_tdata,
  output logic [AXIS_KEEP_W-1:0] tx_tstrb,
  output logic [AXIS_KEEP_W-1:0] tx_tkeep,
  output logic [ID_W-1:0]        tx_tid,
  output logic [DEST_W-1:0]      tx_tdest,
  output logic [USER_W-1:0]      tx_tuser,
  output logic                   tx_tlast,
  input  logic                   tx_tready
);

  packer_state_e      state;
  logic [COUNT_W-1:0] count;
  flit_t              acc;
  flit_t              merged;
  flit_t              load_flit;
  logic               accept;
  logic               complete;
  logic               flush;
  logic               slot_free;
  logic               load;

  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (count == COUNT_W'(WORDS_PER_FLIT - 1)));

  // acc lanes above count are always zero, so merging is a plain lane write.
  always_comb begin
    merged = acc;
    merged.data[WORD_W * count +: WORD_W] = in_data;
    merged.keep[BYTES_PER_WORD * count +: BYTES_PER_WORD] = '1;
    if (count == '0) begin
      merged.id   = cfg_tid;
      merged.dest = cfg_tdest;
      merged.user = cfg_tuser;
    end
    merged.last = in_last;
  end

`ifdef MVM_PACKER_FLUSH_TIMEOUT_EN
  localparam int unsigned IDLE_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  logic [IDLE_W-1:0] idle_cnt;

  assign flush = (state == FILL) && !accept && (count != '0) &&
                 (idle_cnt == IDLE_W'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || accept || (state != FILL) || (count == '0)) begin
      idle_cnt <= '0;
    end else if (!flush) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign flush = 1'b0;
`endif

  // A flushed partial flit already sits in acc with last=0.
  always_comb begin
    load_flit = merged;
    if ((state == HOLD) || flush) begin
      load_flit = acc;
    end
  end

  assign load = slot_free && ((state == HOLD) || complete || flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      count    <= '0;
      acc      <= '0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (complete || flush) begin
            count <= '0;
            if (slot_free) begin
              acc <= '0;
            end else begin
              state    <= HOLD;
              in_ready <= 1'b0;
              if (complete) begin
                acc <= merged;
              end
            end
          end else if (accept) begin
            acc   <= merged;
            count <= count + 1'b1;
          end
        end
        HOLD: begin
          if (slot_free) begin
            acc      <= '0;
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  mvm_axis_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .flit      (load_flit),
    .tx_tready (tx_tready),
    .slot_free (slot_free),
    .tx_tvalid (tx_tvalid),
    .tx_tdata  (tx_tdata),
    .tx_tstrb  (tx_tstrb),
    .tx_tkeep  (tx_tkeep),
    .tx_tid    (tx_tid),
    .tx_tdest  (tx_tdest),
    .tx_tuser  (tx_tuser),
    .tx_tlast  (tx_tlast)
  );

endmodule

// File: tb/tb_mvm_word_packer.sv
// Directed, table-driven bench for mvm_word_packer with multi-cycle sequences
// for backpressure, reset and the optional idle flush.
`timescale 1ns/1ps
module tb_mvm_word_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [7:0]   cfg_tid = '0;
  logic [7:0]   cfg_tdest = '0;
  logic [31:0]  cfg_tuser = '0;
  logic         tx_tvalid;
  logic [511:0] tx_tdata;
  logic [63:0]  tx_tstrb;
  logic [63:0]  tx_tkeep;
  logic [7:0]   tx_tid;
  logic [7:0]   tx_tdest;
  logic [31:0]  tx_tuser;
  logic         tx_tlast;
  logic         tx_tready = 1'b0;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  mvm_word_packer #(.FLUSH_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .cfg_tid   (cfg_tid),
    .cfg_tdest (cfg_tdest),
    .cfg_tuser (cfg_tuser),
    .tx_tvalid (tx_tvalid),
    .tx_tdata  (tx_tdata),
    .tx_tstrb  (tx_tstrb),
    .tx_tkeep  (tx_tkeep),
    .tx_tid    (tx_tid),
    .tx_tdest  (tx_tdest),
    .tx_tuser  (tx_tuser),
    .tx_tlast  (tx_tlast),
    .tx_tready (tx_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [63:0]  strb;
    logic [7:0]   id;
    logic [7:0]   dest;
    logic [31:0]  user;
    logic         last;
    int           start_cyc;
    int           end_cyc;
  } rec_t;

  typedef struct {
    int          n;
    logic [31:0] base;
    logic        lastf;
    logic [7:0]  tid;
    logic [7:0]  tdest;
    logic [31:0] tuser;
    logic [63:0] keep;
    logic        last_exp;
  } vec_t;

  rec_t         q[$];
  int           acc_cnt = 0;
  logic         prev_pending = 1'b0;
  logic [511:0] prev_data = '0;
  logic [177:0] prev_side = '0;
  logic [177:0] side_now;
  int           cur_start = 0;

  assign side_now = {tx_tvalid, tx_tkeep, tx_tstrb, tx_tid, tx_tdest, tx_tuser, tx_tlast};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Samples 1ns before each rising edge: records handshakes and checks that a
  // stalled flit does not change.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        chk("stall_data", tx_tdata, prev_data);
        chk("stall_side", 512'(side_now), 512'(prev_side));
      end
      if (in_valid && in_ready) acc_cnt++;
      if (tx_tvalid && !prev_pending) cur_start = cyc;
      if (tx_tvalid && tx_tready) begin
        rec_t r;
        r.data = tx_tdata;  r.keep = tx_tkeep; r.strb = tx_tstrb;
        r.id = tx_tid;      r.dest = tx_tdest; r.user = tx_tuser;
        r.last = tx_tlast;  r.start_cyc = cur_start; r.end_cyc = cyc;
        q.push_back(r);
      end
      prev_pending = tx_tvalid && !tx_tready;
      prev_data    = tx_tdata;
      prev_side    = side_now;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    for (int t = 0; t < 400 && !done; t++) begin
      #3;
      if (in_ready) begin
        acc_cyc = cyc;
        done = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end
  endtask

  task automatic chk_flit(input string name, input rec_t r, input logic [511:0] data,
                          input logic [63:0] keep, input logic last);
    chk({name, "_data"}, r.data, data);
    chk({name, "_keep"}, 512'(r.keep), 512'(keep));
    chk({name, "_strb"}, 512'(r.strb), 512'(keep));
    chk({name, "_last"}, 512'(r.last), 512'(last));
  endtask

  initial begin
    #500000;
    failed++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1);
  end

  vec_t         vecs[7];
  logic [511:0] exp_data;
  rec_t         r;
  int           ac;
  int           base_cnt;
  int           drop_words;

  initial begin
    vecs[0] = '{16, 32'h0000_0000, 1'b1, 8'h01, 8'h00, 32'hDEAD_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[1] = '{3,  32'h0000_000A, 1'b1, 8'h02, 8'h05, 32'h1234_5678, 64'h0000_0000_0000_0FFF, 1'b1};
    vecs[2] = '{1,  32'h0000_0100, 1'b1, 8'h33, 8'h44, 32'hCAFE_F00D, 64'h0000_0000_0000_000F, 1'b1};
    vecs[3] = '{2,  32'h0000_0200, 1'b1, 8'h5A, 8'hA5, 32'h0BAD_BEEF, 64'h0000_0000_0000_00FF, 1'b1};
    vecs[4] = '{16, 32'h0000_0300, 1'b0, 8'h77, 8'h11, 32'h0000_0042, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[5] = '{15, 32'h0000_0400, 1'b1, 8'h80, 8'h08, 32'h8000_0001, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[6] = '{8,  32'h0000_0500, 1'b1, 8'hFE, 8'hEF, 32'h5555_AAAA, 64'h0000_0000_FFFF_FFFF, 1'b1};

    // Reset state
    @(negedge clk);
    #1;
    idle(2);
    #3;
    chk("reset_in_ready", 512'(in_ready), 512'(0));
    chk("reset_tdata", tx_tdata, 512'(0));
    chk("reset_side", 512'(side_now), 512'(0));
    @(negedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("pre_release_in_ready", 512'(in_ready), 512'(0));
    @(negedge clk);
    #1;
    #3;
    chk("post_release_in_ready", 512'(in_ready), 512'(1));
    @(negedge clk);
    #1;

    // Table vectors, no backpressure; cfg changes after word 0 must be ignored
    tx_tready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      q.delete();
      exp_data = '0;
      for (int k = 0; k < vecs[v].n; k++) begin
        if (k == 0) begin
          cfg_tid = vecs[v].tid; cfg_tdest = vecs[v].tdest; cfg_tuser = vecs[v].tuser;
        end else begin
          cfg_tid = ~vecs[v].tid; cfg_tdest = ~vecs[v].tdest; cfg_tuser = ~vecs[v].tuser;
        end
        exp_data[32*k +: 32] = vecs[v].base + 32'(k);
        send(vecs[v].base + 32'(k), vecs[v].lastf && (k == vecs[v].n - 1), ac);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      idle(3);
      chk($sformatf("vec%0d_count", v), 512'(q.size()), 512'(1));
      if (q.size() > 0) begin
        r = q.pop_front();
        chk_flit($sformatf("vec%0d", v), r, exp_data, vecs[v].keep, vecs[v].last_exp);
        chk($sformatf("vec%0d_tid", v), 512'(r.id), 512'(vecs[v].tid));
        chk($sformatf("vec%0d_tdest", v), 512'(r.dest), 512'(vecs[v].tdest));
        chk($sformatf("vec%0d_tuser", v), 512'(r.user), 512'(vecs[v].tuser));
        chk($sformatf("vec%0d_latency", v), 512'(r.start_cyc), 512'(ac + 1));
      end
    end

    // 48 back-to-back words; the 20-cycle stall starts when in_ready drops
    q.delete();
    tx_tready = 1'b0;
    base_cnt = acc_cnt;
    drop_words = -1;
    fork
      begin : feeder
        for (int i = 0; i < 48; i++) send(32'h1000 + 32'(i), (i == 47), ac);
        in_valid = 1'b0;
        in_last = 1'b0;
      end
      begin : stall_ctl
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
          #3;
          if (!in_ready) begin
            seen = 1'b1;
            drop_words = acc_cnt - base_cnt;
          end
          @(negedge clk);
          #1;
        end
        idle(20);
        tx_tready = 1'b1;
      end
    join
    idle(10);
    chk("stall_drop_after_words", 512'(drop_words), 512'(32));
    chk("stall_flit_count", 512'(q.size()), 512'(3));
    if (q.size() == 3) begin
      for (int f = 0; f < 3; f++) begin
        exp_data = '0;
        for (int k = 0; k < 16; k++) exp_data[32*k +: 32] = 32'h1000 + 32'(16*f + k);
        chk_flit($sformatf("stall_flit%0d", f), q[f], exp_data, '1, (f == 2));
      end
      chk("stall_no_bubble", 512'(q[1].start_cyc), 512'(q[0].end_cyc + 1));
    end

    // Reset mid-packet: only the post-reset words form a flit
    q.delete();
    for (int i = 0; i < 7; i++) send(32'h700 + 32'(i), 1'b0, ac);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    send(32'h800, 1'b0, ac);
    send(32'h801, 1'b1, ac);
    in_valid = 1'b0;
    in_last = 1'b0;
    idle(4);
    chk("rst_pkt_count", 512'(q.size()), 512'(1));
    if (q.size() > 0) begin
      r = q.pop_front();
      exp_data = '0;
      exp_data[63:0] = 64'h0000_0801_0000_0800;
      chk_flit("rst_pkt", r, exp_data, 64'hFF, 1'b1);
    end

    // Reset mid-stall: pending output flit and partial acc both vanish
    q.delete();
    tx_tready = 1'b0;
    for (int i = 0; i < 21; i++) send(32'h900 + 32'(i), 1'b0, ac);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    tx_tready = 1'b1;
    rst = 1'b0;
    idle(30);
    chk("rst_stall_no_flit", 512'(q.size()), 512'(0));
    #3;
    chk("rst_stall_tvalid", 512'(tx_tvalid), 512'(0));
    @(negedge clk);
    #1;

    // Idle flush of a 5-word partial flit
    q.delete();
    for (int i = 0; i < 5; i++) send(32'h5000 + 32'(i), 1'b0, ac);
    in_valid = 1'b0;
    idle(20);
`ifdef MVM_PACKER_FLUSH_TIMEOUT_EN
    chk("flush_count", 512'(q.size()), 512'(1));
    if (q.size() > 0) begin
      r = q.pop_front();
      exp_data = '0;
      for (int k = 0; k < 5; k++) exp_data[32*k +: 32] = 32'h5000 + 32'(k);
      chk_flit("flush", r, exp_data, 64'hF_FFFF, 1'b0);
      chk("flush_latency", 512'(r.start_cyc), 512'(ac + 9));
    end
`else
    idle(80);
    chk("no_flush_count", 512'(q.size()), 512'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mvm_word_packer.md
MVM_WORD_PACKER -- requirements
Module: mvm_word_packer

Interface
REQ-001 Parameter FLUSH_TIMEOUT, default 64: idle cycles before a partial flit is flushed; used only with the timeout feature (REQ-030).
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  upstream 32-bit word valid.
REQ-005 in_data  in  32  word payload.
REQ-006 in_last  in  1  marks final word of a packet.
REQ-007 in_ready  out  1  word accepted when in_valid && in_ready.
REQ-008 cfg_tid / cfg_tdest  in  8 each  stream ID and destination for the packet.
REQ-009 cfg_tuser  in  32  sideband for the packet.
REQ-010 tx_tvalid, tx_tdata[511:0], tx_tstrb[63:0], tx_tkeep[63:0], tx_tid[7:0], tx_tdest[7:0], tx_tuser[31:0], tx_tlast  out  AXI-stream flit toward the mvm rx port.
REQ-011 tx_tready  in  1  downstream accepts flit when tx_tvalid && tx_tready.

Function
REQ-012 Accepted word k of a flit (k = 0..15) SHALL be placed in tx_tdata[32k+31:32k]; unused lanes SHALL be zero.
REQ-013 A flit SHALL complete on its 16th accepted word or on a word accepted with in_last=1.
REQ-014 tx_tkeep and tx_tstrb SHALL be identical, with 4 bits set per valid word from bit 0 upward: 0xFFFF_FFFF_FFFF_FFFF for full flits, 0x0000_0000_0000_00FF for 2 words.
REQ-015 tx_tlast SHALL be 1 only on a flit completed by in_last.
REQ-016 cfg_tid/cfg_tdest/cfg_tuser SHALL be sampled on the first accepted word of each flit and held with that flit.
REQ-017 Storage: one accumulation register (acc, word count 0..15) and one output register (tx_* outputs).
REQ-018 States: FILL (in_ready=1) and HOLD (in_ready=0, acc holds a completed flit).
REQ-019 FILL, completing word, output slot free (tx_tvalid=0 or tx_tready=1): flit SHALL load into the output register; tx_tvalid=1 on the next cycle; count returns to 0; stay in FILL.
REQ-020 FILL, completing word, output slot busy: flit SHALL stay in acc and go to HOLD.
REQ-021 HOLD, output slot free: acc SHALL move to the output register, count clears, and the FSM returns to FILL.
REQ-022 Latency: completing word in cycle N gives tx_tvalid in cycle N+1 when not backpressured; sustained throughput is 1 word/cycle.
REQ-023 Once asserted, tx_tvalid and all tx_* outputs SHALL stay stable until tx_tready=1.
REQ-024 Output register SHALL load and drain in the same cycle with no bubble.
REQ-025 in_ready SHALL be a registered function of the state only; it SHALL NOT depend on in_valid or in_last.
REQ-026 Flits SHALL leave in acceptance order; no word is dropped or duplicated.

Reset
REQ-027 When rst=1 at a clock edge: state=FILL, count=0, acc cleared, tx_tvalid=0, tx_tlast=0, tx_tdata/tkeep/tstrb/tid/tdest/tuser=0, in_ready=0 during reset and 1 the cycle after deassertion.
REQ-028 Reset mid-packet or mid-stall SHALL discard acc and any pending output flit; nothing is emitted after reset until new words arrive.
REQ-029 The timeout counter SHALL clear on reset.

Configuration
REQ-030 Macro MVM_PACKER_FLUSH_TIMEOUT_EN, when defined: in FILL with count>0, FLUSH_TIMEOUT consecutive cycles with no accepted word SHALL complete the partial flit with tx_tlast=0; the counter resets on every accepted word.
REQ-031 Without the macro: a partial flit SHALL be held indefinitely until in_last or the 16th word, and no timeout counter is synthesized.

Structure
REQ-032 Package mvm_pkg SHALL hold AXIS_DATA_W=512, AXIS_KEEP_W=64, WORD_W=32, WORDS_PER_FLIT=16, ID_W=8, DEST_W=8, USER_W=32, and the packer state enum {FILL, HOLD}.
REQ-033 One sub-module, mvm_axis_out_reg, SHALL hold the output register and its stall/load logic; the FSM and acc stay in mvm_word_packer.

Verification
REQ-034 Send 16 words 0x00..0x0F, last on the 16th, tx_tready=1: one flit with tdata word k = k, tkeep all-ones, tlast=1, tx_tvalid exactly one cycle after the 16th word.
REQ-035 Send 3 words 0xA,0xB,0xC with last on 0xC and cfg_tdest=0x05: tkeep=0xFFF, upper lanes zero, tdest=0x05, tlast=1.
REQ-036 Send 48 back-to-back words, tx_tready=0 for 20 cycles then 1: in_ready drops after word 32, three flits arrive in order with no loss, and outputs stay stable while stalled.
REQ-037 Assert rst after 7 words of a packet, then send 2 words with last: exactly one flit with tkeep=0xFF and tlast=1.
REQ-038 With MVM_PACKER_FLUSH_TIMEOUT_EN and FLUSH_TIMEOUT=8, send 5 words with no last, then idle: a flit with tkeep=0xFFFFF and tlast=0 appears 9 cycles after the 5th word; without the macro, no flit appears.
